// File: rtl/cpu_hazard_pkg.sv
// Shared definitions for the operand-hazard logic: register-file geometry,
// bypass stage numbering and the bypass-entry record.
package cpu_hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  // Data is carried at the widest supported datapath; narrower XLEN zero-extends.
  localparam int BYP_DATA_W = 64;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [REG_ADDR_W-1:0] rd;
    logic [BYP_DATA_W-1:0] data;
  } byp_entry_t;

endpackage

// File: rtl/fwd_select.sv
// Priority bypass mux for one source operand of one lane: youngest matching
// bypass entry wins, and a not-yet-valid youngest match falls back to RF data.
module fwd_select
  import cpu_hazard_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int XLEN    = 32,
  parameter int NSTG    = 3,
  parameter int LANE    = 0
) (
  input  logic [REG_ADDR_W-1:0]              src,
  input  logic [XLEN-1:0]                    rf_data,
  input  logic [NSTG*ISSUE_W-1:0]            byp_valid,
  input  logic [NSTG*ISSUE_W-1:0]            byp_wen,
  input  logic [NSTG*ISSUE_W*REG_ADDR_W-1:0] byp_rd,
  input  logic [NSTG*ISSUE_W*XLEN-1:0]       byp_data,
  output logic [XLEN-1:0]                    data,
  output logic                               err
);

  byp_entry_t cur_ent;
  byp_entry_t hit_ent;
  logic       hit;

  // Walk from lowest to highest priority so the last match written is the youngest.
  always_comb begin
    cur_ent = '0;
    hit_ent = '0;
    hit     = 1'b0;
    for (int s = NSTG - 1; s >= 0; s--) begin
      for (int l = 0; l < ISSUE_W; l++) begin
        cur_ent.valid = byp_valid[s*ISSUE_W + l];
        cur_ent.wen   = byp_wen[s*ISSUE_W + l];
        cur_ent.rd    = byp_rd[(s*ISSUE_W + l)*REG_ADDR_W +: REG_ADDR_W];
        cur_ent.data  = BYP_DATA_W'(byp_data[(s*ISSUE_W + l)*XLEN +: XLEN]);
        if (cur_ent.wen && cur_ent.rd == src && !(s == STG_EX && l >= LANE)) begin
          hit     = 1'b1;
          hit_ent = cur_ent;
        end
      end
    end
  end

  always_comb begin
    data = rf_data;
    err  = 1'b0;
    if (src != '0 && hit) begin
      if (hit_ent.valid) begin
        data = hit_ent.data[XLEN-1:0];
      end else begin
        err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_n.sv
// N-issue operand hazard unit: per-register latency scoreboard that gates
// bundle issue, plus youngest-first operand forwarding for every lane.
module fwd_scoreboard_n
  import cpu_hazard_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int XLEN    = 32,
  parameter int NSTG    = 3,
  parameter int LAT_W   = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [ISSUE_W-1:0]                 issue_valid,
  output logic                               issue_ready,
  input  logic [ISSUE_W*REG_ADDR_W-1:0]      issue_rd,
  input  logic [ISSUE_W-1:0]                 issue_wen,
  input  logic [ISSUE_W*LAT_W-1:0]           issue_lat,
  input  logic [ISSUE_W*REG_ADDR_W-1:0]      issue_rs1,
  input  logic [ISSUE_W*REG_ADDR_W-1:0]      issue_rs2,
  input  logic [ISSUE_W*REG_ADDR_W-1:0]      ex_rs1,
  input  logic [ISSUE_W*REG_ADDR_W-1:0]      ex_rs2,
  input  logic [ISSUE_W*XLEN-1:0]            rf_rs1_data,
  input  logic [ISSUE_W*XLEN-1:0]            rf_rs2_data,
  input  logic [NSTG*ISSUE_W-1:0]            byp_valid,
  input  logic [NSTG*ISSUE_W-1:0]            byp_wen,
  input  logic [NSTG*ISSUE_W*REG_ADDR_W-1:0] byp_rd,
  input  logic [NSTG*ISSUE_W*XLEN-1:0]       byp_data,
  output logic [ISSUE_W*XLEN-1:0]            op1_data,
  output logic [ISSUE_W*XLEN-1:0]            op2_data,
  output logic                               fwd_err,
  output logic [31:0]                        stall_cnt
);

  logic [LAT_W-1:0]      cnt_q [NUM_REGS];
  logic [LAT_W-1:0]      cnt_d [NUM_REGS];
  logic [31:0]           stall_cnt_q, stall_cnt_d;
  logic                  ready;
  logic                  fire;
  logic [REG_ADDR_W-1:0] chk_src;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [ISSUE_W-1:0]    err1, err2;

  // A source stalls on a busy scoreboard entry or on a multi-cycle producer earlier in the bundle.
  always_comb begin
    ready   = 1'b1;
    chk_src = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      for (int k = 0; k < 2; k++) begin
        chk_src = (k == 0) ? issue_rs1[i*REG_ADDR_W +: REG_ADDR_W]
                           : issue_rs2[i*REG_ADDR_W +: REG_ADDR_W];
        if (issue_valid[i] && chk_src != '0) begin
          if (cnt_q[chk_src] != '0) ready = 1'b0;
          for (int j = 0; j < i; j++) begin
            if (issue_valid[j] && issue_wen[j] &&
                issue_lat[j*LAT_W +: LAT_W] != '0 &&
                issue_rd[j*REG_ADDR_W +: REG_ADDR_W] == chk_src)
              ready = 1'b0;
          end
        end
      end
    end
  end

  assign fire = issue_valid[0] && ready;

  always_comb begin
    ld_rd = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : cnt_q[r];
    end
    if (fire) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        ld_rd = issue_rd[i*REG_ADDR_W +: REG_ADDR_W];
        if (issue_valid[i] && issue_wen[i] && ld_rd != '0)
          cnt_d[ld_rd] = issue_lat[i*LAT_W +: LAT_W];
      end
    end
    cnt_d[0] = '0;
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_d[r] = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_valid[0] && !ready && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_lane
    fwd_select #(.ISSUE_W(ISSUE_W), .XLEN(XLEN), .NSTG(NSTG), .LANE(gi)) u_op1 (
      .src       (ex_rs1[gi*REG_ADDR_W +: REG_ADDR_W]),
      .rf_data   (rf_rs1_data[gi*XLEN +: XLEN]),
      .byp_valid (byp_valid),
      .byp_wen   (byp_wen),
      .byp_rd    (byp_rd),
      .byp_data  (byp_data),
      .data      (op1_data[gi*XLEN +: XLEN]),
      .err       (err1[gi])
    );
    fwd_select #(.ISSUE_W(ISSUE_W), .XLEN(XLEN), .NSTG(NSTG), .LANE(gi)) u_op2 (
      .src       (ex_rs2[gi*REG_ADDR_W +: REG_ADDR_W]),
      .rf_data   (rf_rs2_data[gi*XLEN +: XLEN]),
      .byp_valid (byp_valid),
      .byp_wen   (byp_wen),
      .byp_rd    (byp_rd),
      .byp_data  (byp_data),
      .data      (op2_data[gi*XLEN +: XLEN]),
      .err       (err2[gi])
    );
  end

  assign issue_ready = ready;
  assign fwd_err     = |{err1, err2};
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/fwd_scoreboard_n.md
Name: fwd_scoreboard_n

Overview:
- Parametrised operand-hazard unit for the N-issue in-order pipeline; generalises the dual-issue ID/EX rs2 forwarding to both source operands on every lane.
- Adds a per-register latency scoreboard and an issue handshake, so the unit stalls the bundle itself instead of relying on external finish flags.
- Sits between ID (issue check) and EX (operand selection).

Parameters:
- ISSUE_W, 2, lanes per bundle; lane ISSUE_W-1 is youngest.
- XLEN, 32, datapath width.
- NSTG, 3, bypass stages: stage 0 = same-bundle EX, 1 = EX/MEM, 2 = MEM/WB.
- LAT_W, 2, width of the producer latency field; max latency is 2^LAT_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  pipeline flush
- issue_valid  in  ISSUE_W  per-lane valid of the ID bundle; contiguous from lane 0
- issue_ready  out  1  bundle may issue this cycle
- issue_rd  in  ISSUE_W*5  destination per lane
- issue_wen  in  ISSUE_W  lane writes rd
- issue_lat  in  ISSUE_W*LAT_W  cycles until the result is forwardable (0 = ALU)
- issue_rs1, issue_rs2  in  ISSUE_W*5  sources per lane
- ex_rs1, ex_rs2  in  ISSUE_W*5  EX-stage sources
- rf_rs1_data, rf_rs2_data  in  ISSUE_W*XLEN  register-file read data
- byp_valid  in  NSTG*ISSUE_W  bypass entry holds final data
- byp_wen  in  NSTG*ISSUE_W  bypass entry writes rd
- byp_rd  in  NSTG*ISSUE_W*5  bypass destination
- byp_data  in  NSTG*ISSUE_W*XLEN  bypass data
- op1_data, op2_data  out  ISSUE_W*XLEN  fresh operands
- fwd_err  out  1  youngest match not yet valid
- stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
- Scoreboard:
  - cnt[r] is LAT_W bits for r = 1..31; x0 is never busy.
  - Every cycle, each nonzero cnt decrements by 1.
- Issue fires when issue_valid[0] && issue_ready.
  - On fire, each valid lane with wen && rd != 0 loads cnt[rd] <= lat.
  - An issue load overrides the decrement of the same register in the same cycle.
  - If two lanes load the same rd, the higher lane wins.
- issue_ready = 0 if any valid lane has either of:
  - a source s != 0 with cnt[s] != 0;
  - a source equal to the rd of a lower valid lane with wen and lat != 0 (same-bundle load-use).
- Same-bundle dependence with lat == 0 does not stall; stage 0 resolves it.
- flush: all cnt cleared next cycle. flush has priority over a simultaneous issue load. issue_ready is unaffected in the flush cycle.
- Operand select (combinational) for lane i, source s:
  - s == 0 -> rf data (zero).
  - Otherwise take the first match with byp_wen && byp_rd == s, in this order: stage 0 lanes i-1 down to 0 (lanes >= i excluded); then stage 1 lanes ISSUE_W-1 down to 0; and so on to stage NSTG-1.
  - Matched entry valid -> byp_data.
  - Matched entry not valid -> rf data, and fwd_err = 1.
  - No match -> rf data.
  - An older valid entry never overrides a younger invalid match.
- stall_cnt:
  - Increments on cycles with issue_valid[0] && !issue_ready.
  - Saturates at 0xFFFFFFFF.
  - Not cleared by flush.
- Reset (rst_n low, async): all cnt = 0, stall_cnt = 0. issue_ready then reads 1. op*_data follow inputs; fwd_err = 0 when bypass inputs are idle.
- Reset mid-operation: pending counts are discarded immediately.

Decomposition:
- Shared package cpu_hazard_pkg holds:
  - REG_ADDR_W = 5, NUM_REGS = 32;
  - the stage index constants STG_EX, STG_MEM, STG_WB;
  - a bypass-entry struct {valid, wen, rd, data}.
- One sub-module, fwd_select: the priority mux for a single operand. It is instantiated 2*ISSUE_W times with the lane index as a parameter.

Test Plan:
- Reset: hold rst_n = 0 with issue_valid = 2'b11, then release -> issue_ready = 1, stall_cnt = 0, op1 = rf data.
- Load-use: fire lane0 (rd = 5, lat = 2), then present lane0 rs1 = 5 -> ready = 0 for exactly 2 cycles; stall_cnt = 2.
- Same-bundle, ALU producer: lane0 rd = 7 lat = 0, lane1 rs2 = 7 -> ready = 1. EX stage with byp stage0 lane0 {1, 1, 7, 0xAA} -> lane1 op2 = 0xAA. Lane0 op2 with ex_rs2 = 7 -> rf data, not 0xAA.
- Same-bundle, load producer: lane0 rd = 7 lat = 1, lane1 rs1 = 7 -> ready = 0.
- Priority:
  - r3 present in stage1 lane0 = 0x11 and stage1 lane1 = 0x22, all valid -> 0x22.
  - r3 also in stage0 lane0 = 0x33, ex_rs1 of lane1 = 3 -> 0x33.
  - x0 with matches -> 0.
- Invalid youngest match: stage1 lane1 {valid = 0, rd = 4} and stage2 {valid = 1, rd = 4, 0x55} -> rf data and fwd_err = 1.
- Flush: fire rd = 9 lat = 3 with flush = 1 in the same cycle -> next cycle rs1 = 9 is ready.
- Async reset mid-count: pulse rst_n low between clock edges -> all registers ready immediately.
